memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
MEM stage of the five-stage pipeline, directly downstream of execution_top. Contains the EX/MEM pipeline register and captures the ALU result, store data, branch target, zero flag and control bits each cycle. Performs word loads and stores on the data memory through a req/ack handshake, stalls upstream while an access is outstanding, and resolves branches. Drives the registered MEM/WB outputs.

Parameters:
DATA_W, 32, data and address width
REG_W, 5, destination register index width
TIMEOUT, 15, maximum cycles waiting for i_dmem_ack before abort (>=1)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  EX stage holds a valid instruction
i_alu_result  in  DATA_W  ALU result / memory address
i_src2  in  DATA_W  store data
i_br_address  in  DATA_W  branch target
i_zero  in  1  ALU zero flag
i_branch  in  1  instruction is beq
i_mem_read  in  1  load
i_mem_write  in  1  store
i_reg_write  in  1  writes register file
i_mem_to_reg  in  1  WB selects memory data
i_write_reg  in  REG_W  destination register
o_stall  out  1  hold EX and earlier stages
o_pc_src  out  1  branch taken
o_br_target  out  DATA_W  taken-branch PC
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = store
o_dmem_addr  out  DATA_W  word address (byte address, bits[1:0]=0)
o_dmem_wdata  out  DATA_W  store data
i_dmem_ack  in  1  access complete; rdata valid this cycle
i_dmem_rdata  in  DATA_W  load data
o_wb_valid  out  1  MEM/WB holds a valid instruction
o_wb_reg_write  out  1  register write enable to WB
o_wb_mem_to_reg  out  1  WB mux select
o_wb_write_reg  out  REG_W  destination register
o_wb_alu_result  out  DATA_W  ALU result
o_wb_read_data  out  DATA_W  load data
o_err  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset: all registers are 0, FSM is IDLE and wait counter is 0. All outputs are 0 while i_rst is high. A reset during an access drops o_dmem_req immediately and abandons the transaction.
- EX/MEM register (m_*): loads all inputs on a clock edge when o_stall=0 and holds them when o_stall=1. m_valid=0 is a bubble; a bubble never requests, stalls or branches.
- mem_op = m_valid & (m_mem_read | m_mem_write). If both bits are set, the access is a store.
- misaligned = mem_op & (m_alu_result[1:0] != 0). No request is issued. The instruction retires in one cycle with o_err pulsed and reg_write forced to 0.
- FSM IDLE / WAIT:
  - IDLE: for an aligned mem_op, o_dmem_req=1 combinationally. If i_dmem_ack is seen in the same cycle, the access completes with no stall. Otherwise go to WAIT with the counter at 1.
  - WAIT: o_dmem_req=1. Address, we and wdata are held stable. On ack, the access completes and the FSM returns to IDLE. If counter==TIMEOUT without ack, abort: o_err pulses, reg_write is forced to 0, the instruction retires and the FSM returns to IDLE. Otherwise the counter increments.
  - If ack and timeout occur in the same cycle, ack wins.
- o_stall = aligned mem_op & ~i_dmem_ack & ~timeout_abort.
- MEM/WB register: loads every cycle. o_wb_valid = m_valid & ~o_stall. While stalled, a bubble is written (valid=0, reg_write=0). o_wb_read_data takes i_dmem_rdata on a load-ack cycle and 0 otherwise. o_err is registered with the MEM/WB outputs.
- Branch: o_pc_src = m_valid & m_branch & m_zero; o_br_target = m_br_address. Both are combinational from m_*. A branch never stalls.
- Latency: 1 cycle from MEM entry to WB for non-memory ops and zero-wait accesses. Otherwise 1 cycle plus the number of wait cycles.

Decomposition:
- Shared package/header mem_stage_defs: FSM state encodings (IDLE=0, WAIT=1), DATA_W/REG_W defaults, and the word-alignment mask constant.
- One sub-module ex_mem_reg: parameterised enable register with async active-high reset, holding the EX/MEM fields. memory_stage instantiates it with enable = ~o_stall.

Test Plan:
- After reset, add, alu_result=0x1234, reg_write=1, write_reg=5 -> next cycle o_wb_valid=1, o_wb_alu_result=0x1234, o_wb_write_reg=5, o_stall never high.
- Load addr=0x40, ack 3 cycles after req -> o_dmem_req high for 4 cycles with addr stable; o_stall high 3 cycles; WB shows read_data=0xDEADBEEF, mem_to_reg=1; three bubbles precede it.
- Store addr=0x80, wdata=0xA5A5A5A5, ack same cycle -> o_dmem_we=1 for one cycle, no stall, o_wb_reg_write=0.
- Load addr=0x42 -> no o_dmem_req, o_err pulse, o_wb_valid=1 with o_wb_reg_write=0.
- Load with ack never asserted, TIMEOUT=15 -> 15 stall cycles, then o_err pulse, req drops; the next instruction enters MEM.
- beq with zero=1, br_address=0x100 -> o_pc_src=1 and o_br_target=0x100 in the same cycle. Assert i_rst mid-WAIT -> req, stall and WB outputs go to 0 immediately.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, FSM states
// and the mask selecting the byte-offset bits of a word address.
package mem_stage_defs;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_stage_ex_mem_reg.sv
// EX/MEM pipeline register: a flat enable register with async active-high reset.
module ex_mem_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, data-memory req/ack handshake with timeout,
// branch resolution and the registered MEM/WB outputs.
module memory_stage
  import mem_stage_defs::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_src2,
  input  logic [DATA_W-1:0] i_br_address,
  input  logic              i_zero,
  input  logic              i_branch,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [REG_W-1:0]  i_write_reg,
  output logic              o_stall,
  output logic              o_pc_src,
  output logic [DATA_W-1:0] o_br_target,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_reg_write,
  output logic              o_wb_mem_to_reg,
  output logic [REG_W-1:0]  o_wb_write_reg,
  output logic [DATA_W-1:0] o_wb_alu_result,
  output logic [DATA_W-1:0] o_wb_read_data,
  output logic              o_err
);

  localparam int unsigned EX_W  = 3 * DATA_W + REG_W + 7;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [EX_W-1:0]   ex_d;
  logic [EX_W-1:0]   ex_q;

  logic              m_valid;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_src2;
  logic [DATA_W-1:0] m_br_address;
  logic              m_zero;
  logic              m_branch;
  logic              m_mem_read;
  logic              m_mem_write;
  logic              m_reg_write;
  logic              m_mem_to_reg;
  logic [REG_W-1:0]  m_write_reg;

  mem_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;

  logic              mem_op;
  logic              misaligned;
  logic              aligned_op;
  logic              timeout_abort;
  logic              retire;
  logic              load_ack;

  assign ex_d = {i_valid, i_alu_result, i_src2, i_br_address, i_zero, i_branch,
                 i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_write_reg};

  ex_mem_reg #(.W(EX_W)) u_ex_mem_reg (
    .clk (i_clk),
    .rst (i_rst),
    .en  (~o_stall),
    .d   (ex_d),
    .q   (ex_q)
  );

  assign {m_valid, m_alu_result, m_src2, m_br_address, m_zero, m_branch,
          m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg, m_write_reg} = ex_q;

  assign mem_op        = m_valid & (m_mem_read | m_mem_write);
  assign misaligned    = mem_op & (|(m_alu_result[1:0] & WORD_ALIGN_MASK));
  assign aligned_op    = mem_op & ~misaligned;
  // An ack arriving in the timeout cycle still completes the access.
  assign timeout_abort = (state == ST_WAIT) & (wait_cnt == CNT_W'(TIMEOUT)) & ~i_dmem_ack;
  assign o_stall       = aligned_op & ~i_dmem_ack & ~timeout_abort;
  assign retire        = m_valid & ~o_stall;
  assign load_ack      = aligned_op & ~m_mem_write & i_dmem_ack;

  // Address/data come straight from the held EX/MEM fields, so they stay
  // stable for the whole outstanding access.
  assign o_dmem_req   = aligned_op;
  assign o_dmem_we    = aligned_op & m_mem_write;
  assign o_dmem_addr  = {m_alu_result[DATA_W-1:2], 2'b00};
  assign o_dmem_wdata = m_src2;

  assign o_pc_src    = m_valid & m_branch & m_zero;
  assign o_br_target = m_br_address;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aligned_op && !i_dmem_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (i_dmem_ack || timeout_abort || !aligned_op) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_valid      <= 1'b0;
      o_wb_reg_write  <= 1'b0;
      o_wb_mem_to_reg <= 1'b0;
      o_wb_write_reg  <= '0;
      o_wb_alu_result <= '0;
      o_wb_read_data  <= '0;
      o_err           <= 1'b0;
    end else begin
      o_wb_valid      <= retire;
      o_wb_reg_write  <= retire & m_reg_write & ~misaligned & ~timeout_abort;
      o_wb_mem_to_reg <= retire & m_mem_to_reg;
      o_wb_write_reg  <= m_write_reg;
      o_wb_alu_result <= m_alu_result;
      o_wb_read_data  <= load_ack ? i_dmem_rdata : '0;
      o_err           <= misaligned | timeout_abort;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a scoreboard queue of expected MEM/WB
// results is drained by a monitor whenever o_wb_valid is seen.
module tb_memory_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned TO = 15;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_alu_result, i_src2, i_br_address;
  logic          i_zero, i_branch, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg;
  logic [RW-1:0] i_write_reg;
  logic          o_stall, o_pc_src;
  logic [DW-1:0] o_br_target;
  logic          o_dmem_req, o_dmem_we;
  logic [DW-1:0] o_dmem_addr, o_dmem_wdata;
  logic          i_dmem_ack;
  logic [DW-1:0] i_dmem_rdata;
  logic          o_wb_valid, o_wb_reg_write, o_wb_mem_to_reg;
  logic [RW-1:0] o_wb_write_reg;
  logic [DW-1:0] o_wb_alu_result, o_wb_read_data;
  logic          o_err;

  typedef struct packed {
    logic          rw;
    logic          mtr;
    logic [RW-1:0] wr;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic          err;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  memory_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .i_alu_result    (i_alu_result),
    .i_src2          (i_src2),
    .i_br_address    (i_br_address),
    .i_zero          (i_zero),
    .i_branch        (i_branch),
    .i_mem_read      (i_mem_read),
    .i_mem_write     (i_mem_write),
    .i_reg_write     (i_reg_write),
    .i_mem_to_reg    (i_mem_to_reg),
    .i_write_reg     (i_write_reg),
    .o_stall         (o_stall),
    .o_pc_src        (o_pc_src),
    .o_br_target     (o_br_target),
    .o_dmem_req      (o_dmem_req),
    .o_dmem_we       (o_dmem_we),
    .o_dmem_addr     (o_dmem_addr),
    .o_dmem_wdata    (o_dmem_wdata),
    .i_dmem_ack      (i_dmem_ack),
    .i_dmem_rdata    (i_dmem_rdata),
    .o_wb_valid      (o_wb_valid),
    .o_wb_reg_write  (o_wb_reg_write),
    .o_wb_mem_to_reg (o_wb_mem_to_reg),
    .o_wb_write_reg  (o_wb_write_reg),
    .o_wb_alu_result (o_wb_alu_result),
    .o_wb_read_data  (o_wb_read_data),
    .o_err           (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_in;
    i_valid      = 1'b0;
    i_alu_result = '0;
    i_src2       = '0;
    i_br_address = '0;
    i_zero       = 1'b0;
    i_branch     = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    i_reg_write  = 1'b0;
    i_mem_to_reg = 1'b0;
    i_write_reg  = '0;
  endtask

  task automatic send(input logic [31:0] alu, input logic [31:0] src2, input logic [31:0] br,
                      input logic zero, input logic branch, input logic rd, input logic wr,
                      input logic rw, input logic mtr, input logic [RW-1:0] wreg);
    i_valid      = 1'b1;
    i_alu_result = alu;
    i_src2       = src2;
    i_br_address = br;
    i_zero       = zero;
    i_branch     = branch;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_reg_write  = rw;
    i_mem_to_reg = mtr;
    i_write_reg  = wreg;
  endtask

  // Monitor: every retiring instruction must match the oldest expectation.
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got retire with alu %h, want none", o_wb_alu_result);
      end else begin
        e = exp_q.pop_front();
        chk("wb_reg_write",  32'(o_wb_reg_write),  32'(e.rw));
        chk("wb_mem_to_reg", 32'(o_wb_mem_to_reg), 32'(e.mtr));
        chk("wb_write_reg",  32'(o_wb_write_reg),  32'(e.wr));
        chk("wb_alu_result", o_wb_alu_result,      e.alu);
        chk("wb_read_data",  o_wb_read_data,       e.rd);
        chk("wb_err",        32'(o_err),           32'(e.err));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, want finish before 50000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned stall_cnt;
    int unsigned req_cnt;
    bit          done;

    i_rst        = 1'b1;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = '0;
    clear_in();
    // A load presented during reset must not reach the memory port.
    send(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req",       32'(o_dmem_req), 32'd0);
    chk("rst_stall",     32'(o_stall),    32'd0);
    chk("rst_wb_valid",  32'(o_wb_valid), 32'd0);
    chk("rst_err",       32'(o_err),      32'd0);
    chk("rst_pc_src",    32'(o_pc_src),   32'd0);
    chk("rst_wb_alu",    o_wb_alu_result, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    clear_in();
    step();

    // ALU op, single-cycle through MEM
    send(32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
    exp_q.push_back('{rw: 1'b1, mtr: 1'b0, wr: 5'd5, alu: 32'h1234, rd: 32'h0, err: 1'b0});
    step();
    clear_in();
    @(negedge i_clk);
    chk("add_stall", 32'(o_stall),    32'd0);
    chk("add_req",   32'(o_dmem_req), 32'd0);
    step();
    @(negedge i_clk);
    chk("add_wb_valid", 32'(o_wb_valid), 32'd1);
    step();

    // Load with ack three cycles after request
    send(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    exp_q.push_back('{rw: 1'b1, mtr: 1'b1, wr: 5'd7, alu: 32'h40, rd: 32'hDEADBEEF, err: 1'b0});
    step();
    clear_in();
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hDEADBEEF;
      end
      @(negedge i_clk);
      chk("ld_req",      32'(o_dmem_req), 32'd1);
      chk("ld_addr",     o_dmem_addr,     32'h40);
      chk("ld_we",       32'(o_dmem_we),  32'd0);
      chk("ld_bubble",   32'(o_wb_valid), 32'd0);
      if (o_stall === 1'b1) stall_cnt++;
      step();
    end
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = '0;
    @(negedge i_clk);
    chk("ld_stall_cycles", stall_cnt, 32'd3);
    chk("ld_wb_valid",     32'(o_wb_valid), 32'd1);
    chk("ld_req_drop",     32'(o_dmem_req), 32'd0);
    step();

    // Store acknowledged in the same cycle
    send(32'h80, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    exp_q.push_back('{rw: 1'b0, mtr: 1'b0, wr: 5'd0, alu: 32'h80, rd: 32'h0, err: 1'b0});
    step();
    clear_in();
    i_dmem_ack = 1'b1;
    @(negedge i_clk);
    chk("st_req",   32'(o_dmem_req), 32'd1);
    chk("st_we",    32'(o_dmem_we),  32'd1);
    chk("st_addr",  o_dmem_addr,     32'h80);
    chk("st_wdata", o_dmem_wdata,    32'hA5A5A5A5);
    chk("st_stall", 32'(o_stall),    32'd0);
    step();
    i_dmem_ack = 1'b0;
    @(negedge i_clk);
    chk("st_we_one_cycle", 32'(o_dmem_we),  32'd0);
    chk("st_wb_valid",     32'(o_wb_valid), 32'd1);
    step();

    // Misaligned load retires at once with an error
    send(32'h42, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    exp_q.push_back('{rw: 1'b0, mtr: 1'b1, wr: 5'd9, alu: 32'h42, rd: 32'h0, err: 1'b1});
    step();
    clear_in();
    @(negedge i_clk);
    chk("mis_req",   32'(o_dmem_req), 32'd0);
    chk("mis_stall", 32'(o_stall),    32'd0);
    step();
    @(negedge i_clk);
    chk("mis_err", 32'(o_err), 32'd1);
    step();
    @(negedge i_clk);
    chk("mis_err_pulse", 32'(o_err), 32'd0);
    step();

    // Load that is never acknowledged, followed by an ALU op
    send(32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    exp_q.push_back('{rw: 1'b0, mtr: 1'b1, wr: 5'd3, alu: 32'h44, rd: 32'h0, err: 1'b1});
    exp_q.push_back('{rw: 1'b1, mtr: 1'b0, wr: 5'd4, alu: 32'h55, rd: 32'h0, err: 1'b0});
    step();
    send(32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
    stall_cnt = 0;
    req_cnt   = 0;
    done      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_dmem_req === 1'b1) req_cnt++;
      if (o_stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      step();
      if (done) break;
    end
    clear_in();
    @(negedge i_clk);
    chk("to_ended",        32'(done),       32'd1);
    chk("to_stall_cycles", stall_cnt,       32'd15);
    chk("to_req_cycles",   req_cnt,         32'd16);
    chk("to_req_drop",     32'(o_dmem_req), 32'd0);
    chk("to_err",          32'(o_err),      32'd1);
    step();
    @(negedge i_clk);
    chk("to_next_retired", 32'(o_wb_valid), 32'd1);
    step();

    // Branches: taken and not taken
    send(32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    exp_q.push_back('{rw: 1'b0, mtr: 1'b0, wr: 5'd0, alu: 32'h0, rd: 32'h0, err: 1'b0});
    step();
    clear_in();
    @(negedge i_clk);
    chk("beq_pc_src",    32'(o_pc_src), 32'd1);
    chk("beq_br_target", o_br_target,   32'h100);
    chk("beq_stall",     32'(o_stall),  32'd0);
    step();
    send(32'h0, 32'h0, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    exp_q.push_back('{rw: 1'b0, mtr: 1'b0, wr: 5'd0, alu: 32'h0, rd: 32'h0, err: 1'b0});
    step();
    clear_in();
    @(negedge i_clk);
    chk("bne_pc_src",    32'(o_pc_src), 32'd0);
    chk("bne_br_target", o_br_target,   32'h200);
    step();
    step();

    // Reset while an access is outstanding
    send(32'h48, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
    step();
    clear_in();
    repeat (3) step();
    @(negedge i_clk);
    chk("rw_req_before", 32'(o_dmem_req), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rw_req",      32'(o_dmem_req),     32'd0);
    chk("rw_stall",    32'(o_stall),        32'd0);
    chk("rw_wb_valid", 32'(o_wb_valid),     32'd0);
    chk("rw_wb_alu",   o_wb_alu_result,     32'd0);
    chk("rw_wb_wreg",  32'(o_wb_write_reg), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();
    @(negedge i_clk);
    chk("rw_req_after",   32'(o_dmem_req), 32'd0);
    chk("rw_stall_after", 32'(o_stall),    32'd0);
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
